// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite bus types and the byte-lane helper used by SRAM-style responders.
// No logic of its own; latency and backpressure are defined by the importing modules.
package ahb_sram_slave_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } transfer_kind;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'b000,
        SIZE_HALF = 3'b001,
        SIZE_WORD = 3'b010
    } transfer_size;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } transfer_response;

    // Lanes written by a transfer; unsupported sizes enable nothing.
    function automatic logic [3:0] byte_lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << addr_lo;
            SIZE_HALF: return 4'b0011 << addr_lo;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/bus_sram_array.sv
// DEPTH_WORDS x 32 SRAM with byte write enables and a one-cycle registered read.
// Never stalls; read data holds until the next read enable (read-first on a same-word write).
module bus_sram_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: data phase 1+WAIT_STATES cycles after acceptance, ERROR takes two.
// Holds ready low only in wait states and ERR1; ready_in gates acceptance, not the data phase.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        ready_in,
    input  logic [1:0]  trans,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [2:0]  burst,
    input  logic [3:0]  prot,
    input  logic        mastlock,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        resp
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_STATES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic [2:0]    state;
    logic [2:0]    wcnt;
    logic          cur_write;
    logic [AW-1:0] cur_word;
    logic [3:0]    cur_be;
    logic          byp_vld;
    logic [3:0]    byp_be;
    logic [31:0]   byp_dat;
    logic [31:0]   rdata_hold;
    logic [31:0]   sram_q;
    logic [31:0]   merged;

    logic          slave_rdy;
    logic          accept;
    logic [31:0]   off;
    logic          size_ok;
    logic          misalign;
    logic          acc_err;
    logic [AW-1:0] acc_word;
    logic          commit;
    logic          sram_re;
    logic [3:0]    sram_we;
    logic          unused_ok;

    assign unused_ok = ^{burst, prot, mastlock};

    assign slave_rdy = (state != S_WAIT) && (state != S_ERR1);
    assign accept    = sel && ready_in && slave_rdy &&
                       (trans == TRANS_NONSEQ || trans == TRANS_SEQ);

    assign off      = addr - BASE;
    assign size_ok  = (size == SIZE_BYTE) || (size == SIZE_HALF) || (size == SIZE_WORD);
    assign misalign = ((size == SIZE_HALF) && addr[0]) ||
                      ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
    assign acc_err  = (off >= SPAN) || !size_ok || misalign;
    assign acc_word = off[AW+1:2];

    // A write still in its data phase when reset lands must not reach the array.
    assign commit  = (state == S_DATA) && cur_write && !rst;
    assign sram_we = commit ? cur_be : 4'b0000;
    assign sram_re = accept && !acc_err && !write;

    bus_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .we      (sram_we),
        .wr_addr (cur_word),
        .wr_data (wdata),
        .re      (sram_re),
        .rd_addr (acc_word),
        .rd_data (sram_q)
    );

    always_comb begin
        merged = sram_q;
        for (int b = 0; b < 4; b++) begin
            if (byp_vld && byp_be[b]) begin
                merged[8*b +: 8] = byp_dat[8*b +: 8];
            end
        end
    end

    assign rdata = (state == S_DATA && !cur_write) ? merged : rdata_hold;
    assign ready = slave_rdy;
    assign resp  = (state == S_ERR1 || state == S_ERR2) ? RESP_ERROR : RESP_OKAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wcnt       <= 3'd0;
            cur_write  <= 1'b0;
            cur_word   <= '0;
            cur_be     <= 4'b0000;
            byp_vld    <= 1'b0;
            byp_be     <= 4'b0000;
            byp_dat    <= 32'h0;
            rdata_hold <= 32'h0;
        end else begin
            if (state == S_DATA && !cur_write) begin
                rdata_hold <= merged;
            end

            case (state)
                S_WAIT: begin
                    if (wcnt <= 3'd1) begin
                        state <= S_DATA;
                        wcnt  <= 3'd0;
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end
                S_ERR1: state <= S_ERR2;
                default: begin
                    if (!accept) begin
                        state <= S_IDLE;
                    end else if (acc_err) begin
                        state <= S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state <= S_WAIT;
                        wcnt  <= WAIT_LOAD;
                    end else begin
                        state <= S_DATA;
                    end
                end
            endcase

            if (accept) begin
                cur_write <= write;
                cur_word  <= acc_word;
                cur_be    <= byte_lane_mask(size, addr[1:0]);
                // Read of the word being written this cycle sees the array's old contents.
                byp_vld   <= commit && !write && !acc_err && (acc_word == cur_word);
                byp_be    <= cur_be;
                byp_dat   <= wdata;
                if (acc_err && !write) begin
                    rdata_hold <= 32'h0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with no wait states, one with three.
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    logic        clk;
    logic        rst;
    logic        sel0, sel3;
    logic        ready_in;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        mastlock;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata3;
    logic        ready0, ready3;
    logic        resp0, resp3;

    int n_cmp = 0;
    int n_bad = 0;

    ahb_sram_slave #(.DEPTH_WORDS(1024), .BASE(32'h0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .sel(sel0), .ready_in(ready_in), .trans(trans),
        .write(write), .addr(addr), .size(size), .burst(burst), .prot(prot),
        .mastlock(mastlock), .wdata(wdata), .rdata(rdata0), .ready(ready0), .resp(resp0)
    );

    ahb_sram_slave #(.DEPTH_WORDS(1024), .BASE(32'h0), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .sel(sel3), .ready_in(ready_in), .trans(trans),
        .write(write), .addr(addr), .size(size), .burst(burst), .prot(prot),
        .mastlock(mastlock), .wdata(wdata), .rdata(rdata3), .ready(ready3), .resp(resp3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic w, input logic [31:0] a, input logic [2:0] sz);
        trans = t;
        write = w;
        addr  = a;
        size  = sz;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL rst_ready0: got %b want 1", ready0); end
        n_cmp++; if (resp0 !== 1'b0) begin n_bad++; $display("FAIL rst_resp0: got %b want 0", resp0); end
        n_cmp++; if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL rst_rdata0: got %h want 00000000", rdata0); end
        n_cmp++; if (ready3 !== 1'b1) begin n_bad++; $display("FAIL rst_ready3: got %b want 1", ready3); end
        n_cmp++; if (rdata3 !== 32'h0) begin n_bad++; $display("FAIL rst_rdata3: got %h want 00000000", rdata3); end
    endtask

    task automatic test_back_to_back();
        sel0 = 1'b1; sel3 = 1'b0;
        drive(TRANS_NONSEQ, 1'b1, 32'h10, SIZE_WORD);
        step();
        n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_ready: got %b want 1", ready0); end
        wdata = 32'hDEADBEEF;
        drive(TRANS_NONSEQ, 1'b0, 32'h10, SIZE_WORD);
        step();
        n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL b2b_rd_ready: got %b want 1", ready0); end
        n_cmp++; if (resp0 !== 1'b0) begin n_bad++; $display("FAIL b2b_rd_resp: got %b want 0", resp0); end
        n_cmp++; if (rdata0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b_rdata: got %h want deadbeef", rdata0); end
        drive(TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD);
        step();
        n_cmp++; if (rdata0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b_rdata_hold: got %h want deadbeef", rdata0); end
    endtask

    task automatic test_bypass();
        drive(TRANS_NONSEQ, 1'b1, 32'h20, SIZE_WORD);
        step();
        wdata = 32'h11223344;
        drive(TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD);
        step();
        drive(TRANS_NONSEQ, 1'b1, 32'h21, SIZE_BYTE);
        step();
        wdata = 32'h5555AA55;
        drive(TRANS_NONSEQ, 1'b0, 32'h20, SIZE_WORD);
        step();
        n_cmp++; if (rdata0 !== 32'h1122AA44) begin n_bad++; $display("FAIL byp_rdata: got %h want 1122aa44", rdata0); end
        drive(TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD);
        step();
        drive(TRANS_NONSEQ, 1'b0, 32'h20, SIZE_WORD);
        step();
        n_cmp++; if (rdata0 !== 32'h1122AA44) begin n_bad++; $display("FAIL byp_mem: got %h want 1122aa44", rdata0); end
        drive(TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD);
        step();
    endtask

    task automatic test_halfword();
        drive(TRANS_NONSEQ, 1'b1, 32'h30, SIZE_WORD);
        step();
        wdata = 32'h0;
        drive(TRANS_NONSEQ, 1'b1, 32'h32, SIZE_HALF);
        step();
        wdata = 32'hBEEF1234;
        drive(TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD);
        step();
        drive(TRANS_NONSEQ, 1'b0, 32'h30, SIZE_WORD);
        step();
        n_cmp++; if (rdata0 !== 32'hBEEF0000) begin n_bad++; $display("FAIL half_rdata: got %h want beef0000", rdata0); end
        drive(TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD);
        step();
    endtask

    task automatic test_error();
        drive(TRANS_NONSEQ, 1'b1, 32'h04, SIZE_WORD);
        step();
        wdata = 32'hCAFEF00D;
        drive(TRANS_NONSEQ, 1'b1, 32'h05, SIZE_WORD);
        step();
        n_cmp++; if (ready0 !== 1'b0) begin n_bad++; $display("FAIL err_wr_ready1: got %b want 0", ready0); end
        n_cmp++; if (resp0 !== 1'b1) begin n_bad++; $display("FAIL err_wr_resp1: got %b want 1", resp0); end
        wdata = 32'hFFFFFFFF;
        drive(TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD);
        step();
        n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL err_wr_ready2: got %b want 1", ready0); end
        n_cmp++; if (resp0 !== 1'b1) begin n_bad++; $display("FAIL err_wr_resp2: got %b want 1", resp0); end
        step();
        n_cmp++; if (resp0 !== 1'b0) begin n_bad++; $display("FAIL err_wr_after: got %b want 0", resp0); end
        drive(TRANS_NONSEQ, 1'b0, 32'h04, SIZE_WORD);
        step();
        n_cmp++; if (rdata0 !== 32'hCAFEF00D) begin n_bad++; $display("FAIL err_mem_kept: got %h want cafef00d", rdata0); end
        drive(TRANS_NONSEQ, 1'b0, 32'h1000, SIZE_WORD);
        step();
        n_cmp++; if (ready0 !== 1'b0) begin n_bad++; $display("FAIL err_rd_ready1: got %b want 0", ready0); end
        n_cmp++; if (resp0 !== 1'b1) begin n_bad++; $display("FAIL err_rd_resp1: got %b want 1", resp0); end
        n_cmp++; if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL err_rd_rdata1: got %h want 00000000", rdata0); end
        drive(TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD);
        step();
        n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL err_rd_ready2: got %b want 1", ready0); end
        n_cmp++; if (resp0 !== 1'b1) begin n_bad++; $display("FAIL err_rd_resp2: got %b want 1", resp0); end
        n_cmp++; if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL err_rd_rdata2: got %h want 00000000", rdata0); end
        step();
    endtask

    task automatic test_wait_states();
        sel0 = 1'b0; sel3 = 1'b1;
        drive(TRANS_NONSEQ, 1'b1, 32'h40, SIZE_WORD);
        step();
        n_cmp++; if (ready3 !== 1'b0) begin n_bad++; $display("FAIL w3_wr_wait: got %b want 0", ready3); end
        wdata = 32'h01234567;
        drive(TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD);
        step();
        step();
        step();
        n_cmp++; if (ready3 !== 1'b1) begin n_bad++; $display("FAIL w3_wr_data: got %b want 1", ready3); end
        step();
        // Read accepted in "cycle 10".
        drive(TRANS_NONSEQ, 1'b0, 32'h40, SIZE_WORD);
        step();
        n_cmp++; if (ready3 !== 1'b0) begin n_bad++; $display("FAIL w3_c11_ready: got %b want 0", ready3); end
        drive(TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD);
        step();
        n_cmp++; if (ready3 !== 1'b0) begin n_bad++; $display("FAIL w3_c12_ready: got %b want 0", ready3); end
        step();
        n_cmp++; if (ready3 !== 1'b0) begin n_bad++; $display("FAIL w3_c13_ready: got %b want 0", ready3); end
        step();
        n_cmp++; if (ready3 !== 1'b1) begin n_bad++; $display("FAIL w3_c14_ready: got %b want 1", ready3); end
        n_cmp++; if (rdata3 !== 32'h01234567) begin n_bad++; $display("FAIL w3_c14_rdata: got %h want 01234567", rdata3); end
        step();
        n_cmp++; if (ready3 !== 1'b1) begin n_bad++; $display("FAIL w3_c15_ready: got %b want 1", ready3); end
        n_cmp++; if (resp3 !== 1'b0) begin n_bad++; $display("FAIL w3_c15_resp: got %b want 0", resp3); end
        n_cmp++; if (rdata3 !== 32'h01234567) begin n_bad++; $display("FAIL w3_c15_rdata: got %h want 01234567", rdata3); end
    endtask

    task automatic test_error_wait_states();
        drive(TRANS_NONSEQ, 1'b1, 32'h02, SIZE_WORD);
        step();
        n_cmp++; if (ready3 !== 1'b0 || resp3 !== 1'b1) begin n_bad++; $display("FAIL w3_err1: got ready=%b resp=%b want ready=0 resp=1", ready3, resp3); end
        drive(TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD);
        step();
        n_cmp++; if (ready3 !== 1'b1 || resp3 !== 1'b1) begin n_bad++; $display("FAIL w3_err2: got ready=%b resp=%b want ready=1 resp=1", ready3, resp3); end
        step();
        n_cmp++; if (ready3 !== 1'b1 || resp3 !== 1'b0) begin n_bad++; $display("FAIL w3_err_end: got ready=%b resp=%b want ready=1 resp=0", ready3, resp3); end
    endtask

    task automatic test_reset_mid();
        drive(TRANS_NONSEQ, 1'b1, 32'h40, SIZE_WORD);
        step();
        wdata = 32'hFFFFFFFF;
        drive(TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (ready3 !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 1", ready3); end
        n_cmp++; if (resp3 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_resp: got %b want 0", resp3); end
        n_cmp++; if (rdata3 !== 32'h0) begin n_bad++; $display("FAIL mid_rst_rdata: got %h want 00000000", rdata3); end
        drive(TRANS_NONSEQ, 1'b0, 32'h40, SIZE_WORD);
        step();
        drive(TRANS_IDLE, 1'b0, 32'h0, SIZE_WORD);
        step();
        step();
        step();
        n_cmp++; if (ready3 !== 1'b1) begin n_bad++; $display("FAIL mid_rd_ready: got %b want 1", ready3); end
        n_cmp++; if (rdata3 !== 32'h01234567) begin n_bad++; $display("FAIL mid_rd_rdata: got %h want 01234567", rdata3); end
        step();
    endtask

    initial begin
        rst = 1'b1; sel0 = 1'b0; sel3 = 1'b0; ready_in = 1'b1;
        trans = TRANS_IDLE; write = 1'b0; addr = 32'h0; size = SIZE_WORD;
        burst = 3'b000; prot = 4'b0011; mastlock = 1'b0; wdata = 32'h0;
        test_reset();
        test_back_to_back();
        test_bypass();
        test_halfword();
        test_error();
        test_wait_states();
        test_error_wait_states();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
